ram_initiator: RTL
==================

RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 Parameters: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, address width; WAIT_CYCLES, 2, strobe-active cycles per access (legal range 1..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when high with req_valid.
REQ-007 req_we  input  1  1=write, 0=read.
REQ-008 req_addr  input  ADDR_WIDTH  request address.
REQ-009 req_wdata  input  DATA_WIDTH  write data.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  read data consumed when high with rsp_valid.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data.
REQ-013 wr_done  output  1  one-cycle pulse when a write completes.
REQ-014 mem_address  output  ADDR_WIDTH  RAM address.
REQ-015 mem_data  inout  DATA_WIDTH  RAM bidirectional data.
REQ-016 mem_cs, mem_we, mem_oe  output  1 each  RAM chip select, write enable, output enable.

Function
REQ-017 States SHALL be IDLE, SETUP, ACCESS, HOLD, RESP; req_ready SHALL be high exactly in IDLE.
REQ-018 Handshake at edge T (IDLE, req_valid=1): req_we/addr/wdata captured; state SETUP at T+1; inputs otherwise ignored.
REQ-019 SETUP (1 cycle): mem_cs=1, mem_address=captured addr, mem_we=0, mem_oe=0; write data driven on mem_data for writes.
REQ-020 ACCESS (WAIT_CYCLES cycles, cycles T+2..T+1+WAIT_CYCLES): mem_cs=1; mem_we=1 for writes, mem_oe=1 for reads; address and write data stable.
REQ-021 Read data SHALL be sampled from mem_data at the edge ending the last ACCESS cycle.
REQ-022 HOLD (1 cycle, T+2+WAIT_CYCLES): mem_cs=1, mem_we=0, mem_oe=0, address and write data still driven; wr_done=1 for writes only.
REQ-023 After HOLD: writes go to IDLE (req_ready high at T+3+WAIT_CYCLES); reads go to RESP.
REQ-024 RESP: rsp_valid=1, rsp_rdata stable, until rsp_valid&&rsp_ready, then IDLE; no new request accepted in RESP.
REQ-025 mem_data SHALL be driven only in SETUP/ACCESS/HOLD of a write; high-Z in all other states; never driven while mem_oe=1.
REQ-026 mem_we and mem_oe SHALL never be high simultaneously; neither SHALL be high while mem_cs=0.
REQ-027 All mem_* outputs, rsp_valid, rsp_rdata, wr_done SHALL be registered (glitch-free).
REQ-028 mem_cs=0 in IDLE and RESP; mem_address holds its last value outside an access.
REQ-029 Wait counter SHALL be 4 bits, load WAIT_CYCLES-1 on entering ACCESS, decrement to 0, no wrap.
REQ-030 Back-to-back requests: a request held valid during the response cycle SHALL be accepted in the first IDLE cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, mem_cs=0, mem_we=0, mem_oe=0, mem_address=0, mem_data high-Z, rsp_valid=0, rsp_rdata=0, wr_done=0, counter=0; req_ready=1 after release.
REQ-032 Reset mid-access SHALL abort the access; no rsp_valid or wr_done for it after release.

Structure
REQ-033 Package ram_if_pkg SHALL hold the state enum and default DATA_WIDTH/ADDR_WIDTH/WAIT_CYCLES constants.
REQ-034 Single module; no sub-module is natural (tri-state driver and counter inline).

Verification
REQ-035 Write addr=0x10, data=0xDEADBEEF, WAIT_CYCLES=2 -> mem_we high cycles T+2..T+3, wr_done at T+4, RAM model word 0x10=0xDEADBEEF.
REQ-036 Read addr=0x10 after REQ-035 with rsp_ready=1 -> rsp_valid at T+5, rsp_rdata=0xDEADBEEF, mem_oe high T+2..T+3.
REQ-037 Read with rsp_ready low 5 cycles -> rsp_valid and rsp_rdata held 5 cycles, req_ready=0 throughout.
REQ-038 Back-to-back write 0x20/0x1 then read 0x20 -> second accepted at T+5, reads 0x00000001; no X on mem_data (no contention).
REQ-039 rst_n low during ACCESS of a read -> strobes drop same cycle, mem_data Z, no rsp_valid after release, req_ready=1.
REQ-040 WAIT_CYCLES=1 and 15 builds -> write latency 4 and 18 cycles to req_ready, protocol assertions (REQ-025/026) never fire.

Source files
------------

// File: rtl/ram_if_pkg.sv
// Shared state encoding and default build constants for the asynchronous SRAM initiator.
package ram_if_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_ADDR_WIDTH  = 32;
   localparam int unsigned DEF_WAIT_CYCLES = 2;
   localparam int unsigned CNT_WIDTH       = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/ram_initiator.sv
// Single-request initiator driving an asynchronous SRAM with a setup / strobe / hold cycle sequence.
// Every strobe, data-bus enable and response output comes straight from a flop.
module ram_initiator
   import ram_if_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  wr_done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe
);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  op_we_q, op_we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  drive_q, drive_d;
   logic                  cs_q, cs_d;
   logic                  we_q, we_d;
   logic                  oe_q, oe_d;
   logic                  wr_done_q, wr_done_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  req_ready_q, req_ready_d;
   logic                  busy_d;

   // Next-state logic; bus outputs are decoded from the next state so they land in flops.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_we_d = op_we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_we_d = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = CNT_WIDTH'(WAIT_CYCLES - 1);
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (!op_we_q) begin
                  rdata_d = mem_data;
               end
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         ST_HOLD: begin
            state_d = op_we_q ? ST_IDLE : ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
      cs_d        = busy_d;
      we_d        = (state_d == ST_ACCESS) && op_we_d;
      oe_d        = (state_d == ST_ACCESS) && !op_we_d;
      drive_d     = busy_d && op_we_d;
      wr_done_d   = (state_d == ST_HOLD) && op_we_d;
      rsp_valid_d = (state_d == ST_RESP);
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_we_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         drive_q     <= 1'b0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         oe_q        <= 1'b0;
         wr_done_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_we_q     <= op_we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         drive_q     <= drive_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
         wr_done_q   <= wr_done_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
      end
   end

   // The bus is only ever driven for writes, so it can never collide with the RAM's read drive.
   assign mem_data    = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign mem_address = addr_q;
   assign mem_cs      = cs_q;
   assign mem_we      = we_q;
   assign mem_oe      = oe_q;
   assign wr_done     = wr_done_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign req_ready   = req_ready_q;

endmodule
